alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage_if.sv | 32 +++
 rtl/alu_result_stage.sv | 114 +++++++++++
 tb/tb_alu_result_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake and result bus for alu_result_stage: upstream push side, downstream pop side, status.
// slave is the stage's view, master is the view of whatever drives it.
interface alu_result_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_sel;
    logic        in_carry;
    logic        in_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_sel;
    logic        out_zero;
    logic        out_neg;
    logic        out_carry;
    logic        out_ovf;
    logic        err_sel;
    logic [15:0] out_count;

    modport slave (
        input  in_valid, in_data, in_sel, in_carry, in_ovf, out_ready,
        output in_ready, out_valid, out_data, out_sel,
               out_zero, out_neg, out_carry, out_ovf, err_sel, out_count
    );

    modport master (
        output in_valid, in_data, in_sel, in_carry, in_ovf, out_ready,
        input  in_ready, out_valid, out_data, out_sel,
               out_zero, out_neg, out_carry, out_ovf, err_sel, out_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// 2-entry result FIFO behind the ALU output mux; flags are computed on push.
// Define ALU_RESULT_STATS_EN to build the saturating accepted-result counter on out_count.
module alu_result_stage (
    input  logic                 clk,
    input  logic                 reset,
    alu_result_stage_if.slave    bus
);
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  sel;
        logic        zero;
        logic        neg;
        logic        carry;
        logic        ovf;
    } entry_t;

    entry_t      mem_q [2];
    entry_t      last_q;
    entry_t      head;
    entry_t      new_entry;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  occ_q, occ_d;
    logic        err_q, err_d;
    logic        push, pop;

    assign bus.in_ready  = (occ_q != 2'd2);
    assign bus.out_valid = (occ_q != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Carry/overflow only mean something for add (sel 0) and sub (sel 1).
    always_comb begin
        new_entry.data  = bus.in_data;
        new_entry.sel   = bus.in_sel;
        new_entry.zero  = (bus.in_data == 32'd0);
        new_entry.neg   = bus.in_data[31];
        new_entry.carry = (bus.in_sel[3:1] == 3'd0) ? bus.in_carry : 1'b0;
        new_entry.ovf   = (bus.in_sel[3:1] == 3'd0) ? bus.in_ovf   : 1'b0;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
            if (bus.in_sel > 4'd4) begin
                err_d = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            err_q    <= 1'b0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
            if (pop) begin
                last_q <= head;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (!reset && push && (wr_ptr_q == gi[0])) begin
                mem_q[gi] <= new_entry;
            end
        end
    end

    // When empty the outputs keep showing the most recently popped entry.
    assign head          = mem_q[rd_ptr_q];
    assign bus.out_data  = bus.out_valid ? head.data  : last_q.data;
    assign bus.out_sel   = bus.out_valid ? head.sel   : last_q.sel;
    assign bus.out_zero  = bus.out_valid ? head.zero  : last_q.zero;
    assign bus.out_neg   = bus.out_valid ? head.neg   : last_q.neg;
    assign bus.out_carry = bus.out_valid ? head.carry : last_q.carry;
    assign bus.out_ovf   = bus.out_valid ? head.ovf   : last_q.ovf;
    assign bus.err_sel   = err_q;

`ifdef ALU_RESULT_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else if (push && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.out_count = cnt_q;
`else
    assign bus.out_count = 16'd0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: flag table, directed FIFO corner cases,
// then random traffic against a queue-based reference model.
module tb_alu_result_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_result_stage_if bus ();

    alu_result_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  sel;
        logic        carry;
        logic        ovf;
        logic [3:0]  exp_flags;   // {zero, neg, carry, ovf}
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic [3:0]  f;
    } ent_t;

    vec_t vecs [6];
    ent_t mq [$];
    ent_t m_last;
    logic m_err;
    int   m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] s,
                         input logic c, input logic o, input logic rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sel    = s;
        bus.in_carry  = c;
        bus.in_ovf    = o;
        bus.out_ready = rdy;
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf};
    endfunction

    function automatic logic [15:0] exp_count(input int n);
`ifdef ALU_RESULT_STATS_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return 16'd0 + 16'(n - n);
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 4'd2, 1'b1, 1'b1, 4'b1000};
        vecs[1] = '{32'h8000_0001, 4'd0, 1'b1, 1'b1, 4'b0111};
        vecs[2] = '{32'h7FFF_FFFF, 4'd1, 1'b1, 1'b0, 4'b0010};
        vecs[3] = '{32'hFFFF_FFFF, 4'd4, 1'b1, 1'b1, 4'b0100};
        vecs[4] = '{32'h0000_0001, 4'd1, 1'b0, 1'b1, 4'b0001};
        vecs[5] = '{32'h0000_0000, 4'd0, 1'b1, 1'b0, 4'b1010};

        do_reset();
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_data", bus.out_data, 32'd0);
        chk("reset flags", 32'(flags_now()), 32'd0);
        chk("reset err_sel", 32'(bus.err_sel), 32'd0);
        chk("reset out_count", 32'(bus.out_count), 32'd0);

        // Flag table: each vector pushed into an empty FIFO, inspected, then popped.
        for (int i = 0; i < 6; i++) begin
            drive(1, vecs[i].data, vecs[i].sel, vecs[i].carry, vecs[i].ovf, 0);
            tick();
            drive(0, 0, 0, 0, 0, 0);
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d data", i), bus.out_data, vecs[i].data);
            chk($sformatf("vec%0d sel", i), 32'(bus.out_sel), 32'(vecs[i].sel));
            chk($sformatf("vec%0d flags", i), 32'(flags_now()), 32'(vecs[i].exp_flags));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            chk($sformatf("vec%0d empty", i), 32'(bus.out_valid), 32'd0);
            chk($sformatf("vec%0d held data", i), bus.out_data, vecs[i].data);
            chk($sformatf("vec%0d held flags", i), 32'(flags_now()), 32'(vecs[i].exp_flags));
        end
        chk("sel4 no err", 32'(bus.err_sel), 32'd0);

        // Fill to two entries, third push refused, pops in order.
        drive(1, 32'h8000_0001, 4'd0, 1, 1, 0);
        tick();
        drive(1, 32'h0000_0004, 4'd3, 1, 1, 0);
        tick();
        chk("full in_ready", 32'(bus.in_ready), 32'd0);
        drive(1, 32'h0000_DEAD, 4'd2, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        chk("full head data", bus.out_data, 32'h8000_0001);
        chk("full head flags", 32'(flags_now()), 32'b0111);
        tick();
        chk("second data", bus.out_data, 32'h0000_0004);
        chk("second flags", 32'(flags_now()), 32'b0000);
        chk("second in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.out_ready = 1'b0;
        chk("third push dropped", 32'(bus.out_valid), 32'd0);

        // Push and pop together at occupancy 1.
        drive(1, 32'h0000_0020, 4'd2, 0, 0, 0);
        tick();
        drive(1, 32'h0000_0010, 4'd2, 0, 0, 1);
        chk("pp old head", bus.out_data, 32'h0000_0020);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("pp out_valid", 32'(bus.out_valid), 32'd1);
        chk("pp in_ready", 32'(bus.in_ready), 32'd1);
        chk("pp new head", bus.out_data, 32'h0000_0010);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pp drained", 32'(bus.out_valid), 32'd0);

        // Pop while empty changes nothing.
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("empty pop valid", 32'(bus.out_valid), 32'd0);
        chk("empty pop data", bus.out_data, 32'h0000_0010);

        // Illegal select is stored and makes err_sel sticky.
        drive(1, 32'h0000_0055, 4'd7, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        chk("sel7 err", 32'(bus.err_sel), 32'd1);
        chk("sel7 out_sel", 32'(bus.out_sel), 32'd7);
        chk("sel7 flags", 32'(flags_now()), 32'b0000);
        tick();
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("sel7 err sticky", 32'(bus.err_sel), 32'd1);

        // Three pushes, then reset mid-stream with a push and pop pending.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'(i + 1), 4'd1, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("stats before reset", 32'(bus.out_count), 32'(exp_count(3)));
        chk("valid before reset", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        drive(1, 32'h0000_0099, 4'd7, 0, 0, 1);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("post reset valid", 32'(bus.out_valid), 32'd0);
        chk("post reset count", 32'(bus.out_count), 32'd0);
        chk("post reset data", bus.out_data, 32'd0);
        chk("post reset err", 32'(bus.err_sel), 32'd0);
        chk("post reset in_ready", 32'(bus.in_ready), 32'd1);

        // Random traffic against the queue model.
        do_reset();
        mq.delete();
        m_last = '{32'd0, 4'd0, 4'd0};
        m_err  = 1'b0;
        m_cnt  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [31:0] d;
            logic [3:0]  s;
            logic        v, c, o, r, rst;
            bit          do_push, do_pop;
            ent_t        e;
            ent_t        exp_head;
            case ($urandom_range(3))
                0:       d = 32'd0;
                1:       d = 32'h8000_0000 | $urandom_range(255);
                default: d = $urandom;
            endcase
            s   = ($urandom_range(15) < 13) ? 4'($urandom_range(4)) : 4'($urandom_range(15));
            v   = ($urandom_range(3) != 0);
            c   = 1'($urandom);
            o   = 1'($urandom);
            r   = 1'($urandom);
            rst = ($urandom_range(199) == 0);
            drive(v, d, s, c, o, r);
            reset = rst;

            exp_head = (mq.size() > 0) ? mq[0] : m_last;
            chk("rnd out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
            chk("rnd in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
            chk("rnd data", bus.out_data, exp_head.d);
            chk("rnd sel_flags", {24'd0, bus.out_sel, flags_now()}, {24'd0, exp_head.s, exp_head.f});
            chk("rnd err_sel", 32'(bus.err_sel), 32'(m_err));
            chk("rnd out_count", 32'(bus.out_count), 32'(exp_count(m_cnt)));

            if (rst) begin
                mq.delete();
                m_last = '{32'd0, 4'd0, 4'd0};
                m_err  = 1'b0;
                m_cnt  = 0;
            end else begin
                do_push = v && (mq.size() < 2);
                do_pop  = r && (mq.size() > 0);
                if (do_pop) m_last = mq.pop_front();
                if (do_push) begin
                    e.d = d;
                    e.s = s;
                    e.f = {d == 32'd0, d[31], (s <= 4'd1) ? c : 1'b0, (s <= 4'd1) ? o : 1'b0};
                    mq.push_back(e);
                    if (s > 4'd4) m_err = 1'b1;
                    m_cnt++;
                end
            end
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
